// File: rtl/decode_queue_pkg.sv
// Shared scalar types (common) and decoded-control definitions (pipes)
// for the decode queue slice.
package common;
   typedef logic [31:0] u32;
   typedef logic [63:0] u64;
endpackage

package pipes;
   import common::*;

   typedef enum logic [4:0] {
      OP_UNKNOWN, OP_ADDI, OP_XORI, OP_ORI, OP_ANDI,
      OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_LUI,
      OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_e;

   typedef enum logic [3:0] {
      ALU_NONE, ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_PASS_IMM,
      ALU_MUL, ALU_MULH, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
   } aluop_e;

   typedef struct packed {
      op_e        op;
      aluop_e     aluop;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      u64         imm;
      logic       reg_write;
      logic       illegal;
   } control_t;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_MULH = 3'b001;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   function automatic u64 sext12(input logic [11:0] v);
      return {{52{v[11]}}, v};
   endfunction
endpackage

// File: rtl/decode_queue_decode.sv
// Combinational RV64 subset decoder: u32 instruction in, control_t out.
// Build option: DECODE_MUL_EN adds the M-extension MUL/MULH/DIV/DIVU/REM/REMU ops.
module decode_logic
   import common::*;
   import pipes::*;
(
   input  u32       instr,
   output control_t ctl
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       legal;
   op_e        op;
   aluop_e     aluop;
   u64         imm;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   always_comb begin
      legal = 1'b0;
      op    = OP_UNKNOWN;
      aluop = ALU_NONE;
      imm   = '0;
      case (opcode)
         OPC_OP_IMM: begin
            imm   = sext12(instr[31:20]);
            legal = 1'b1;
            case (funct3)
               F3_ADD:  begin op = OP_ADDI; aluop = ALU_ADD; end
               F3_XOR:  begin op = OP_XORI; aluop = ALU_XOR; end
               F3_OR:   begin op = OP_ORI;  aluop = ALU_OR;  end
               F3_AND:  begin op = OP_ANDI; aluop = ALU_AND; end
               default: legal = 1'b0;
            endcase
         end
         OPC_LUI: begin
            imm   = {{32{instr[31]}}, instr[31:12], 12'b0};
            op    = OP_LUI;
            aluop = ALU_PASS_IMM;
            legal = 1'b1;
         end
         OPC_OP: begin
            if (funct7 == F7_BASE) begin
               legal = 1'b1;
               case (funct3)
                  F3_ADD:  begin op = OP_ADD; aluop = ALU_ADD; end
                  F3_XOR:  begin op = OP_XOR; aluop = ALU_XOR; end
                  F3_OR:   begin op = OP_OR;  aluop = ALU_OR;  end
                  F3_AND:  begin op = OP_AND; aluop = ALU_AND; end
                  default: legal = 1'b0;
               endcase
            end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
               op    = OP_SUB;
               aluop = ALU_SUB;
               legal = 1'b1;
            end
`ifdef DECODE_MUL_EN
            else if (funct7 == F7_MULDIV) begin
               legal = 1'b1;
               case (funct3)
                  F3_ADD:  begin op = OP_MUL;  aluop = ALU_MUL;  end
                  F3_MULH: begin op = OP_MULH; aluop = ALU_MULH; end
                  F3_XOR:  begin op = OP_DIV;  aluop = ALU_DIV;  end
                  F3_DIVU: begin op = OP_DIVU; aluop = ALU_DIVU; end
                  F3_OR:   begin op = OP_REM;  aluop = ALU_REM;  end
                  F3_AND:  begin op = OP_REMU; aluop = ALU_REMU; end
                  default: legal = 1'b0;
               endcase
            end
`endif
         end
         default: legal = 1'b0;
      endcase

      // Anything not fully recognised collapses to a single canonical illegal form.
      if (!legal) begin
         op    = OP_UNKNOWN;
         aluop = ALU_NONE;
         imm   = '0;
      end

      ctl           = '0;
      ctl.op        = op;
      ctl.aluop     = aluop;
      ctl.rd        = instr[11:7];
      ctl.rs1       = instr[19:15];
      ctl.rs2       = instr[24:20];
      ctl.imm       = imm;
      ctl.reg_write = legal && (instr[11:7] != 5'd0);
      ctl.illegal   = !legal;
   end

endmodule

// File: rtl/decode_queue.sv
// Decode stage queue: decodes incoming instructions and buffers control + PC
// in a DEPTH-entry FIFO. Build option: DECODE_MUL_EN (handled in decode_logic).
module decode_queue
   import common::*;
   import pipes::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  u32               in_instr,
   input  u64               in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output control_t         out_ctl,
   output u64               out_pc,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   control_t dec_ctl;

   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   control_t         ctl_mem_q [DEPTH];
   control_t         ctl_mem_d [DEPTH];
   u64               pc_mem_q  [DEPTH];
   u64               pc_mem_d  [DEPTH];
   logic             push, pop;

   decode_logic u_decode (
      .instr (in_instr),
      .ctl   (dec_ctl)
   );

   assign in_ready  = !reset && !flush && (count_q < DEPTH_C);
   assign out_valid = (count_q != '0);
   assign out_ctl   = ctl_mem_q[rd_ptr_q];
   assign out_pc    = pc_mem_q[rd_ptr_q];
   assign count     = count_q;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      count_d   = count_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      ctl_mem_d = ctl_mem_q;
      pc_mem_d  = pc_mem_q;

      if (push) begin
         ctl_mem_d[wr_ptr_q] = dec_ctl;
         pc_mem_d[wr_ptr_q]  = in_pc;
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end

      // A pop in the flush cycle was already presented to the consumer; the
      // queue is emptied regardless.
      if (flush) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      ctl_mem_q <= ctl_mem_d;
      pc_mem_q  <= pc_mem_d;
   end

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (DEPTH = 4).
// Expectations for the MUL encoding follow DECODE_MUL_EN.
module tb_decode_queue;
   import common::*;
   import pipes::*;

   logic       clk = 1'b0;
   logic       reset, flush, in_valid, out_ready;
   logic       in_ready, out_valid;
   u32         in_instr;
   u64         in_pc;
   control_t   out_ctl;
   u64         out_pc;
   logic [2:0] count;

   int n_checks = 0;
   int n_fails  = 0;

   decode_queue #(.DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctl   (out_ctl),
      .out_pc    (out_pc),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input u32 instr, input u64 pc);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pop1();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      #1;
      chk("in_ready_in_reset", 64'(in_ready), 64'd0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);

      // addi x1,x0,5
      in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 64'h1000;
      #1;
      chk("addi_not_same_cycle", 64'(out_valid), 64'd0);
      tick();
      in_valid = 1'b0;
      #1;
      chk("addi_out_valid", 64'(out_valid), 64'd1);
      chk("addi_op", 64'(out_ctl.op), 64'(OP_ADDI));
      chk("addi_aluop", 64'(out_ctl.aluop), 64'(ALU_ADD));
      chk("addi_rd", 64'(out_ctl.rd), 64'd1);
      chk("addi_imm", out_ctl.imm, 64'd5);
      chk("addi_reg_write", 64'(out_ctl.reg_write), 64'd1);
      chk("addi_illegal", 64'(out_ctl.illegal), 64'd0);
      chk("addi_pc", out_pc, 64'h1000);
      chk("addi_count", 64'(count), 64'd1);
      // held while not consumed
      tick();
      chk("addi_hold_pc", out_pc, 64'h1000);
      chk("addi_hold_op", 64'(out_ctl.op), 64'(OP_ADDI));
      pop1();
      chk("after_pop_count", 64'(count), 64'd0);

      // pop on empty must not move pointers
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("empty_pop_count", 64'(count), 64'd0);
      chk("empty_pop_valid", 64'(out_valid), 64'd0);

      // addi x1,x0,-1 ; lui x0,0x80000 ; sub x5,x6,x7 ; mul x0,x1,x2 (queue full)
      push1(32'hFFF00093, 64'h1100);
      push1(32'h80000037, 64'h1104);
      push1(32'h407302B3, 64'h1108);
      push1(32'h02208033, 64'h110C);
      chk("neg_pc_after_empty_pop", out_pc, 64'h1100);
      chk("neg_imm", out_ctl.imm, 64'hFFFFFFFFFFFFFFFF);
      pop1();
      chk("lui_op", 64'(out_ctl.op), 64'(OP_LUI));
      chk("lui_imm", out_ctl.imm, 64'hFFFFFFFF80000000);
      chk("lui_rd0_reg_write", 64'(out_ctl.reg_write), 64'd0);
      pop1();
      chk("sub_op", 64'(out_ctl.op), 64'(OP_SUB));
      chk("sub_aluop", 64'(out_ctl.aluop), 64'(ALU_SUB));
      chk("sub_rd", 64'(out_ctl.rd), 64'd5);
      chk("sub_rs1", 64'(out_ctl.rs1), 64'd6);
      chk("sub_rs2", 64'(out_ctl.rs2), 64'd7);
      pop1();
`ifdef DECODE_MUL_EN
      chk("mul_op", 64'(out_ctl.op), 64'(OP_MUL));
      chk("mul_aluop", 64'(out_ctl.aluop), 64'(ALU_MUL));
      chk("mul_illegal", 64'(out_ctl.illegal), 64'd0);
`else
      chk("mul_op", 64'(out_ctl.op), 64'(OP_UNKNOWN));
      chk("mul_illegal", 64'(out_ctl.illegal), 64'd1);
`endif
      chk("mul_reg_write", 64'(out_ctl.reg_write), 64'd0);
      chk("mul_rs1", 64'(out_ctl.rs1), 64'd1);
      chk("mul_rs2", 64'(out_ctl.rs2), 64'd2);
      pop1();

      // illegal opcode still enqueued
      push1(32'hFFFFFFFF, 64'h1200);
      chk("unk_valid", 64'(out_valid), 64'd1);
      chk("unk_op", 64'(out_ctl.op), 64'(OP_UNKNOWN));
      chk("unk_illegal", 64'(out_ctl.illegal), 64'd1);
      chk("unk_reg_write", 64'(out_ctl.reg_write), 64'd0);
      pop1();
      chk("unk_drained", 64'(count), 64'd0);

      // offer 5 with out_ready low: only 4 accepted
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_instr = {12'(i + 10), 5'd0, 3'b000, 5'(i + 1), 7'h13};
         in_pc    = 64'h3000 + 64'(4 * i);
         #1;
         chk($sformatf("fill_in_ready_%0d", i), 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
         if (i == 4) begin
            out_ready = 1'b1;
            #1;
            chk("full_no_passthrough", 64'(in_ready), 64'd0);
            out_ready = 1'b0;
         end
         tick();
      end
      in_valid = 1'b0;
      chk("full_count", 64'(count), 64'd4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain_rd_%0d", i), 64'(out_ctl.rd), 64'(i + 1));
         chk($sformatf("drain_imm_%0d", i), out_ctl.imm, 64'(i + 10));
         chk($sformatf("drain_pc_%0d", i), out_pc, 64'h3000 + 64'(4 * i));
         tick();
      end
      out_ready = 1'b0;
      chk("drain_count", 64'(count), 64'd0);
      chk("drain_valid", 64'(out_valid), 64'd0);

      // flush with count = 3 and an offered instruction
      push1(32'h00100093, 64'h4000);
      push1(32'h00200093, 64'h4004);
      push1(32'h00300093, 64'h4008);
      chk("preflush_count", 64'(count), 64'd3);
      in_valid = 1'b1; in_instr = 32'h00400093; in_pc = 64'h400C; flush = 1'b1;
      #1;
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      tick();
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      push1(32'h00700393, 64'h4100);
      chk("postflush_pc", out_pc, 64'h4100);
      chk("postflush_rd", 64'(out_ctl.rd), 64'd7);
      pop1();

      // steady push+pop at count = 2 across pointer wrap
      push1(32'h00100093, 64'h5000);
      push1(32'h00100093, 64'h5008);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_instr = 32'h00100093;
         in_pc    = 64'h5010 + 64'(8 * k);
         #1;
         chk($sformatf("wrap_pc_%0d", k), out_pc, 64'h5000 + 64'(8 * k));
         chk($sformatf("wrap_count_%0d", k), 64'(count), 64'd2);
         tick();
      end
      in_valid = 1'b0;
      chk("wrap_tail0", out_pc, 64'h5040);
      tick();
      chk("wrap_tail1", out_pc, 64'h5048);
      tick();
      out_ready = 1'b0;
      chk("wrap_empty", 64'(count), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter: DEPTH, 4, queue entries; power of two, >= 2.
REQ-002 Parameter: CNT_W, $clog2(DEPTH+1), width of occupancy count.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: flush  input  1  discard all queued entries.
REQ-006 Port: in_valid  input  1  fetch offers an instruction.
REQ-007 Port: in_ready  output  1  queue accepts this cycle.
REQ-008 Port: in_instr  input  32 (u32)  raw instruction.
REQ-009 Port: in_pc  input  64 (u64)  instruction PC.
REQ-010 Port: out_valid  output  1  head entry valid.
REQ-011 Port: out_ready  input  1  execute consumes head.
REQ-012 Port: out_ctl  output  control_t  decoded head control.
REQ-013 Port: out_pc  output  64 (u64)  head PC.
REQ-014 Port: count  output  CNT_W  current occupancy.

Function
REQ-015 The block SHALL decode in_instr combinationally and enqueue decoded control_t plus PC on in_valid && in_ready.
REQ-016 Decoded ops: ADDI, XORI, ORI, ANDI, ADD, SUB, XOR, OR, AND, LUI; aluop per op; rd/rs1/rs2 from instr[11:7]/[19:15]/[24:20].
REQ-017 I-type imm SHALL be instr[31:20] sign-extended to 64; LUI imm SHALL be instr[31:12]<<12 sign-extended from bit 31.
REQ-018 reg_write SHALL be 1 for every decoded op except when rd == 0, where it SHALL be 0.
REQ-019 Unrecognised opcode/funct3/funct7 SHALL yield op = UNKNOWN, illegal = 1, reg_write = 0; entry still enqueued.
REQ-020 in_ready SHALL equal (count < DEPTH) && !flush; no same-cycle pass-through when full, even if out_ready.
REQ-021 Latency: instruction accepted at cycle N appears on out_valid at N+1 earliest; FIFO order preserved.
REQ-022 out_valid SHALL equal (count != 0); dequeue on out_valid && out_ready; out_ctl/out_pc hold stable while out_valid && !out_ready.
REQ-023 Simultaneous enqueue and dequeue SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-024 flush SHALL zero count and both pointers next cycle; concurrent out_ready handshake in the flush cycle is still a valid consume; no enqueue in flush cycle.
REQ-025 Dequeue with count == 0 SHALL be ignored; pointers never advance past empty.

Reset
REQ-026 On reset: count = 0, pointers = 0, out_valid = 0, in_ready = 0 during reset cycle, 1 after.
REQ-027 Storage contents need not reset; out_ctl/out_pc SHALL be don't-care while out_valid = 0.
REQ-028 Reset SHALL take priority over flush and all handshakes.

Configuration
REQ-029 Macro DECODE_MUL_EN: when defined, MUL, MULH, DIV, DIVU, REM, REMU (funct7 = 0000001) SHALL decode to their ops with matching aluop and reg_write per REQ-018.
REQ-030 Without DECODE_MUL_EN those encodings SHALL decode as illegal per REQ-019.

Structure
REQ-031 control_t (op, aluop, rd, rs1, rs2, imm, reg_write, illegal), op/aluop enums and opcode/funct constants SHALL live in package pipes; u32/u64 in common.
REQ-032 Decode logic SHALL be a separate combinational sub-module decode_logic (u32 in, control_t out); queue storage and pointers reside in decode_queue.

Verification
REQ-033 Reset, then in_instr = 0x00500093 (addi x1,x0,5) -> next cycle out_valid = 1, op = ADDI, rd = 1, imm = 5, reg_write = 1.
REQ-034 DEPTH = 4, out_ready = 0, offer 5 instrs -> count = 4, in_ready = 0, 5th not accepted; release -> outputs in order.
REQ-035 0xFFF00093 (addi x1,x0,-1) -> imm = 0xFFFFFFFFFFFFFFFF; 0x80000037 (lui x0) -> imm = 0xFFFFFFFF80000000, reg_write = 0.
REQ-036 count = 3, assert flush with in_valid = 1 -> in_ready = 0, count = 0 next cycle, out_valid = 0.
REQ-037 0x02208033 (mul x0,x1,x2 family, rd = x0) with and without DECODE_MUL_EN -> MUL/reg_write = 0 vs illegal = 1, op = UNKNOWN.
REQ-038 count = 2, simultaneous push and pop for 8 cycles -> count stays 2, pointers wrap, order preserved.
